// File: rtl/apb3_arbiter_if.sv
// Bus bundle for the two-master APB3 arbiter: both upstream master ports,
// the downstream slave port and the status outputs.
interface apb3_arbiter_if #(
   parameter int A_WIDTH  = 32,
   parameter int RD_WIDTH = 32,
   parameter int WD_WIDTH = 32
);
   logic                psel_m0, penable_m0, pwrite_m0, pready_m0;
   logic [A_WIDTH-1:0]  paddr_m0;
   logic [WD_WIDTH-1:0] pwdata_m0;
   logic [RD_WIDTH-1:0] prdata_m0;

   logic                psel_m1, penable_m1, pwrite_m1, pready_m1;
   logic [A_WIDTH-1:0]  paddr_m1;
   logic [WD_WIDTH-1:0] pwdata_m1;
   logic [RD_WIDTH-1:0] prdata_m1;

   logic                psel_s, penable_s, pwrite_s, pready_s;
   logic [A_WIDTH-1:0]  paddr_s;
   logic [WD_WIDTH-1:0] pwdata_s;
   logic [RD_WIDTH-1:0] prdata_s;

   logic                busy, gnt;

   // master: the arbiter's own view; slave: the surrounding masters and slave.
   modport master (
      input  psel_m0, penable_m0, pwrite_m0, paddr_m0, pwdata_m0,
      output prdata_m0, pready_m0,
      input  psel_m1, penable_m1, pwrite_m1, paddr_m1, pwdata_m1,
      output prdata_m1, pready_m1,
      output psel_s, penable_s, pwrite_s, paddr_s, pwdata_s,
      input  prdata_s, pready_s,
      output busy, gnt
   );

   modport slave (
      output psel_m0, penable_m0, pwrite_m0, paddr_m0, pwdata_m0,
      input  prdata_m0, pready_m0,
      output psel_m1, penable_m1, pwrite_m1, paddr_m1, pwdata_m1,
      input  prdata_m1, pready_m1,
      input  psel_s, penable_s, pwrite_s, paddr_s, pwdata_s,
      output prdata_s, pready_s,
      input  busy, gnt
   );
endinterface

// File: rtl/apb3_arbiter.sv
// Round-robin arbiter letting two APB3 masters share one APB3 slave.
// All outputs come straight from flops; masters are sampled only in IDLE.
module apb3_arbiter #(
   parameter int A_WIDTH  = 32,
   parameter int RD_WIDTH = 32,
   parameter int WD_WIDTH = 32
) (
   input logic            clk,
   input logic            prst,
   apb3_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

   state_e              state_q, state_d;
   logic                gnt_q, gnt_d;
   logic                prio_q, prio_d;    // master that wins the next tie
   logic                busy_q, busy_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [A_WIDTH-1:0]  paddr_q, paddr_d;
   logic [WD_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [RD_WIDTH-1:0] prdata_q, prdata_d;
   logic                pready0_q, pready0_d;
   logic                pready1_q, pready1_d;
   logic                grant;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case infers a latch.
      state_d   = state_q;
      gnt_d     = gnt_q;
      prio_d    = prio_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      prdata_d  = prdata_q;
      pready0_d = 1'b0;
      pready1_d = 1'b0;
      grant     = (bus.psel_m0 && bus.psel_m1) ? prio_q : bus.psel_m1;

      case (state_q)
         IDLE: begin
            if (bus.psel_m0 || bus.psel_m1) begin
               gnt_d     = grant;
               prio_d    = ~grant;
               pwrite_d  = grant ? bus.pwrite_m1 : bus.pwrite_m0;
               paddr_d   = grant ? bus.paddr_m1  : bus.paddr_m0;
               pwdata_d  = grant ? bus.pwdata_m1 : bus.pwdata_m0;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (bus.pready_s) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               if (!pwrite_q) prdata_d = bus.prdata_s;
               pready0_d = ~gnt_q;
               pready1_d = gnt_q;
               state_d   = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (prst) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         prio_q    <= 1'b0;
         busy_q    <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         prdata_q  <= '0;
         pready0_q <= 1'b0;
         pready1_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         prio_q    <= prio_d;
         busy_q    <= busy_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         prdata_q  <= prdata_d;
         pready0_q <= pready0_d;
         pready1_q <= pready1_d;
      end
   end

   assign bus.psel_s    = psel_q;
   assign bus.penable_s = penable_q;
   assign bus.pwrite_s  = pwrite_q;
   assign bus.paddr_s   = paddr_q;
   assign bus.pwdata_s  = pwdata_q;
   assign bus.prdata_m0 = prdata_q;
   assign bus.prdata_m1 = prdata_q;
   assign bus.pready_m0 = pready0_q;
   assign bus.pready_m1 = pready1_q;
   assign bus.busy      = busy_q;
   assign bus.gnt       = gnt_q;
endmodule

// File: tb/tb_apb3_arbiter.sv
// Self-checking bench for apb3_arbiter: directed transfer table, reset corner
// cases, then random traffic against a transaction-level round-robin model.
module tb_apb3_arbiter;
   logic clk = 1'b0;
   logic prst;
   always #5 clk = ~clk;

   apb3_arbiter_if #(.A_WIDTH(32), .RD_WIDTH(32), .WD_WIDTH(32)) bus ();

   apb3_arbiter #(.A_WIDTH(32), .RD_WIDTH(32), .WD_WIDTH(32)) u_dut (
      .clk  (clk),
      .prst (prst),
      .bus  (bus.master)
   );

   typedef struct {
      logic        req0, req1, wr0, wr1;
      logic [31:0] a0, a1, d0, d1, sdata;
      int          waits;
      logic        exp_gnt;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[12];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " psel_s"},    32'(bus.psel_s),    0);
      check({tag, " penable_s"}, 32'(bus.penable_s), 0);
      check({tag, " pwrite_s"},  32'(bus.pwrite_s),  0);
      check({tag, " paddr_s"},   bus.paddr_s,        0);
      check({tag, " pwdata_s"},  bus.pwdata_s,       0);
      check({tag, " pready_m0"}, 32'(bus.pready_m0), 0);
      check({tag, " pready_m1"}, 32'(bus.pready_m1), 0);
      check({tag, " prdata_m0"}, bus.prdata_m0,      0);
      check({tag, " prdata_m1"}, bus.prdata_m1,      0);
      check({tag, " busy"},      32'(bus.busy),      0);
      check({tag, " gnt"},       32'(bus.gnt),       0);
   endtask

   // One complete arbitrated transfer starting from IDLE, checked cycle by cycle.
   task automatic run_xfer(input string tag, input logic r0, input logic r1,
                           input logic w0, input logic w1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] sdata, input int waits, input logic drop,
                           input logic eg, input logic [31:0] erd);
      logic [31:0] ea, ed;
      logic        ew;
      ea = eg ? a1 : a0;
      ed = eg ? d1 : d0;
      ew = eg ? w1 : w0;
      bus.psel_m0 = r0; bus.pwrite_m0 = w0; bus.paddr_m0 = a0; bus.pwdata_m0 = d0;
      bus.psel_m1 = r1; bus.pwrite_m1 = w1; bus.paddr_m1 = a1; bus.pwdata_m1 = d1;
      bus.penable_m0 = 1'($urandom_range(0, 1));
      bus.penable_m1 = 1'($urandom_range(0, 1));
      bus.pready_s = 1'b0;
      bus.prdata_s = $urandom;
      tick();
      check({tag, " setup psel_s"},    32'(bus.psel_s),    1);
      check({tag, " setup penable_s"}, 32'(bus.penable_s), 0);
      check({tag, " setup gnt"},       32'(bus.gnt),       32'(eg));
      check({tag, " setup busy"},      32'(bus.busy),      1);
      check({tag, " setup paddr_s"},   bus.paddr_s,        ea);
      check({tag, " setup pwrite_s"},  32'(bus.pwrite_s),  32'(ew));
      check({tag, " setup pwdata_s"},  bus.pwdata_s,       ed);
      if (drop) begin
         if (eg) bus.psel_m1 = 1'b0;
         else    bus.psel_m0 = 1'b0;
      end
      tick();
      for (int i = 0; i <= waits; i++) begin
         check({tag, " access psel_s"},    32'(bus.psel_s),    1);
         check({tag, " access penable_s"}, 32'(bus.penable_s), 1);
         check({tag, " access paddr_s"},   bus.paddr_s,        ea);
         check({tag, " access pwdata_s"},  bus.pwdata_s,       ed);
         check({tag, " access pready_m"},  32'({bus.pready_m1, bus.pready_m0}), 0);
         bus.pready_s = (i == waits);
         bus.prdata_s = (i == waits) ? sdata : $urandom;
         tick();
      end
      check({tag, " done psel_s"},    32'(bus.psel_s),    0);
      check({tag, " done penable_s"}, 32'(bus.penable_s), 0);
      check({tag, " done pready_m"},  32'({bus.pready_m1, bus.pready_m0}), eg ? 32'd2 : 32'd1);
      check({tag, " done prdata_m0"}, bus.prdata_m0,      erd);
      check({tag, " done prdata_m1"}, bus.prdata_m1,      erd);
      check({tag, " done busy"},      32'(bus.busy),      1);
      bus.pready_s = 1'b0;
      tick();
      check({tag, " idle pready_m"},  32'({bus.pready_m1, bus.pready_m0}), 0);
      check({tag, " idle busy"},      32'(bus.busy),      0);
      check({tag, " idle gnt"},       32'(bus.gnt),       32'(eg));
   endtask

   logic        pend[2], mw[2];
   logic [31:0] ma[2], md[2];
   logic        prio, win;
   logic [31:0] mrd, sd;

   initial begin
      vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h30, 32'h11, 32'h22, 32'hDEADBEEF, 0, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h30, 32'h11, 32'h22, 32'hDEADBEEF, 0, 1'b1, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,  32'h0,  32'h0,  32'hA5A5A5A5, 0, 1'b0, 32'hA5A5A5A5};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0,  32'h0,  32'h0,  32'h0000005A, 3, 1'b0, 32'h5A};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 32'h0,  32'h77, 32'h0,  32'hFFFF0000, 1, 1'b0, 32'h5A};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h60, 32'h0,  32'h88, 32'h12345678, 2, 1'b1, 32'h5A};
      for (int i = 6; i < 12; i++)
         vecs[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i),
                     32'hA0 + 32'(i), 32'hB0 + 32'(i), 32'hCAFE0000, i % 3, 1'((i - 6) % 2), 32'h5A};

      bus.psel_m0 = 0; bus.penable_m0 = 0; bus.pwrite_m0 = 0; bus.paddr_m0 = 0; bus.pwdata_m0 = 0;
      bus.psel_m1 = 0; bus.penable_m1 = 0; bus.pwrite_m1 = 0; bus.paddr_m1 = 0; bus.pwdata_m1 = 0;
      bus.pready_s = 0; bus.prdata_s = 0;
      prst = 1'b1;
      tick();
      tick();
      check_all_zero("reset");
      prst = 1'b0;
      tick();
      check_all_zero("post-reset idle");

      for (int i = 0; i < 12; i++)
         run_xfer($sformatf("vec%0d", i), vecs[i].req0, vecs[i].req1, vecs[i].wr0, vecs[i].wr1,
                  vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1, vecs[i].sdata,
                  vecs[i].waits, 1'b0, vecs[i].exp_gnt, vecs[i].exp_rd);

      // Granted master drops psel right after SETUP; the transfer still completes.
      run_xfer("drop", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h70, 32'h0, 32'h0,
               32'h0BADF00D, 1, 1'b1, 1'b1, 32'h0BADF00D);

      // Reset in the middle of a wait-stated ACCESS.
      bus.psel_m0 = 1'b1; bus.pwrite_m0 = 1'b0; bus.paddr_m0 = 32'h88;
      bus.psel_m1 = 1'b0; bus.pready_s = 1'b0;
      tick();
      tick();
      check("midreset penable_s before", 32'(bus.penable_s), 1);
      prst = 1'b1;
      tick();
      check_all_zero("midreset");
      prst = 1'b0;
      bus.psel_m0 = 1'b0;
      bus.pready_s = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("midreset no pready", 32'({bus.pready_m1, bus.pready_m0}), 0);
         check("midreset stays idle", 32'(bus.busy), 0);
      end
      bus.pready_s = 1'b0;

      // Random traffic against a transaction-level model of the arbitration rules.
      pend[0] = 1'b0; pend[1] = 1'b0;
      mw[0] = 1'b0; mw[1] = 1'b0;
      ma[0] = 0; ma[1] = 0; md[0] = 0; md[1] = 0;
      prio = 1'b0;
      mrd  = 32'h0;
      for (int n = 0; n < 60; n++) begin
         for (int m = 0; m < 2; m++)
            if (!pend[m] && $urandom_range(0, 1) == 1) begin
               pend[m] = 1'b1;
               mw[m]   = 1'($urandom_range(0, 1));
               ma[m]   = $urandom;
               md[m]   = $urandom;
            end
         if (!pend[0] && !pend[1]) begin
            pend[0] = 1'b1; mw[0] = 1'b0; ma[0] = $urandom; md[0] = $urandom;
         end
         win  = (pend[0] && pend[1]) ? prio : pend[1];
         prio = ~win;
         sd   = $urandom;
         if (!mw[win]) mrd = sd;
         run_xfer($sformatf("rand%0d", n), pend[0], pend[1], mw[0], mw[1], ma[0], ma[1],
                  md[0], md[1], sd, $urandom_range(0, 3), 1'($urandom_range(0, 1)), win, mrd);
         pend[win] = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
